sig_frame_sequencer: RTL and testbench
======================================

# sig_frame_sequencer

Frame sequencer for the signal-processing path. On a `start` pulse from the signal parameter registers, it reads `FRAME_WORDS` 32-bit words from memory starting at `start_addr_read` and streams them into the processing datapath. It writes the same number of datapath results back to memory starting at `start_addr_write`, then pulses `irq` into the parameter block, which latches it as the CPU interrupt. The read side and the write side run concurrently, so a pipelined datapath stays full.

## Interface
- `FRAME_WORDS`, default 256: words per frame, range 1..65535.
- `ADDR_STEP`, default 4: byte increment per word.
- `clk`  in  1: single clock, all logic on its rising edge.
- `rst`  in  1: reset, asynchronous assert, active-low (0 = reset).
- `start`  in  1: one-cycle start pulse.
- `start_addr_read`  in  32: frame source byte address, sampled on accepted `start`.
- `start_addr_write`  in  32: frame destination byte address, sampled on accepted `start`.
- `irq`  out  1: one-cycle frame-complete pulse.
- `busy`  out  1: high from accepted `start` through the `irq` cycle.
- `avm_rd_address`  out  32: read master address.
- `avm_rd_read`  out  1: read request.
- `avm_rd_waitrequest`  in  1: read stall.
- `avm_rd_readdata`  in  32: read data.
- `avm_rd_readdatavalid`  in  1: read data valid.
- `avm_wr_address`  out  32: write master address.
- `avm_wr_write`  out  1: write request.
- `avm_wr_writedata`  out  32: write data.
- `avm_wr_waitrequest`  in  1: write stall.
- `dp_in_data`  out  32: word to datapath.
- `dp_in_valid`  out  1: word valid.
- `dp_in_ready`  in  1: datapath accepts.
- `dp_out_data`  in  32: result from datapath.
- `dp_out_valid`  in  1: result valid.
- `dp_out_ready`  out  1: sequencer accepts.

## Operation
- Top FSM has three states: IDLE, RUN, DONE.
  - IDLE → RUN on `start`=1. In the same edge, the addresses are latched and the read and write counters are cleared.
  - RUN → DONE when the write count reaches `FRAME_WORDS`.
  - DONE → IDLE unconditionally. `irq`=1 only in DONE.
- `start` outside IDLE is ignored. No latching, no restart.
- The read sub-FSM is active in RUN and has four states: R_REQ, R_WAIT, R_PUSH, R_END.
  - R_REQ: `avm_rd_read`=1 with `avm_rd_address`=base+rd_cnt·`ADDR_STEP`, both held stable while `avm_rd_waitrequest`=1. It moves to R_WAIT on the edge where waitrequest=0.
  - R_WAIT: waits for `avm_rd_readdatavalid`, captures `avm_rd_readdata`, then moves to R_PUSH.
  - R_PUSH: `dp_in_valid`=1 with the captured word held. On `dp_in_ready`=1, rd_cnt increments. It then goes to R_REQ, or to R_END if rd_cnt reaches `FRAME_WORDS`.
  - Exactly one read is outstanding at a time. `readdatavalid` outside R_WAIT is ignored.
- The write sub-FSM is active in RUN and has two states: W_ACC and W_WR.
  - W_ACC: `dp_out_ready`=1 while wr_cnt<`FRAME_WORDS`. On valid&ready it captures `dp_out_data` and moves to W_WR.
  - W_WR: `avm_wr_write`=1 with address=base+wr_cnt·`ADDR_STEP`, held while waitrequest=1. On acceptance, wr_cnt increments and the sub-FSM returns to W_ACC.
- Results beyond `FRAME_WORDS` are never accepted: `dp_out_ready`=0 outside RUN and once the count is reached.
- Address arithmetic is 32-bit unsigned and wraps modulo 2^32. Counters are 16 bits wide.
- Reset (any time, including mid-frame) returns all FSMs to IDLE immediately. Any in-flight bus transaction is abandoned.

## Timing
- Reset values of all outputs are 0: `irq`, `busy`, `avm_rd_read`, `avm_wr_write`, `dp_in_valid`, `dp_out_ready`, both addresses, `avm_wr_writedata`, `dp_in_data`.
- `start` seen at edge k means:
  - `busy`=1 and `avm_rd_read`=1 in cycle k+1.
  - `dp_out_ready`=1 in cycle k+1.
- Read side minimum per word, with zero wait states and readdatavalid the cycle after acceptance: 3 cycles (REQ, WAIT, PUSH).
- Write side minimum per word: 2 cycles (ACC, WR).
- The last write is accepted at edge m. DONE is cycle m+1 with `irq`=1 and `busy`=1. Cycle m+2 is IDLE with `busy`=0.
- All outputs are registered. Master request signals never drop while the matching waitrequest=1.

## Test plan
- **Identity frame:** `FRAME_WORDS`=4, identity datapath, memory 0x1000..0x100C = 0x11,0x22,0x33,0x44, start with read 0x1000 and write 0x2000.
  - 0x2000..0x200C must equal 0x11..0x44.
  - Exactly one `irq` pulse.
  - `busy` falls the cycle after `irq`.
- **Wait states:** random 0–5 cycle `waitrequest` on both masters plus 0–3 cycle readdatavalid delay.
  - Data must be identical to the identity-frame case.
  - Address and request must stay stable throughout every stall.
- **Datapath backpressure and latency:** `dp_in_ready` 50% duty, datapath with 7-cycle pipeline latency, `FRAME_WORDS`=16.
  - All 16 words are written in order.
  - A 17th `dp_out_valid` is not accepted (`dp_out_ready`=0).
- **Start while busy:** second `start` with different addresses mid-frame.
  - Ignored: original destination only, one `irq`.
  - A fresh `start` after IDLE runs a new frame correctly.
- **Reset mid-frame:** assert `rst`=0 during W_WR of word 2.
  - All outputs go to 0 asynchronously.
  - No `irq`.
  - The next frame after release completes normally.
- **Address wrap:** write base 0xFFFFFFF8, `FRAME_WORDS`=4.
  - Writes go to 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004.

Source files
------------

// File: rtl/sig_frame_sequencer.sv
// -----------------------------------------------------------------------------
// sig_frame_sequencer
//
// Moves one frame of FRAME_WORDS 32-bit words from memory through the
// processing datapath and back to memory. A read master fetches words and
// feeds the datapath. A write master drains datapath results to the
// destination. Both run concurrently, so a pipelined datapath stays full.
// A one-cycle irq marks completion of the frame.
//
// Parameters
//   FRAME_WORDS : words per frame (1..65535)
//   ADDR_STEP   : byte address increment per word
//
// Ports
//   clk, rst                : clock; asynchronous active-low reset
//   start                   : one-cycle start pulse, honoured only when idle
//   start_addr_read/_write  : frame source/destination byte addresses
//   irq, busy               : frame-complete pulse, frame-in-progress flag
//   avm_rd_*                : read master with a single outstanding read
//   avm_wr_*                : write master
//   dp_in_*                 : valid/ready stream into the datapath
//   dp_out_*                : valid/ready stream of results from the datapath
//
// Every output is a flop. Its next value is decoded from the next-state
// values, so each output already reflects the state it belongs to.
// -----------------------------------------------------------------------------
module sig_frame_sequencer #(
  parameter int unsigned FRAME_WORDS = 256,
  parameter int unsigned ADDR_STEP   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] start_addr_read,
  input  logic [31:0] start_addr_write,
  output logic        irq,
  output logic        busy,
  output logic [31:0] avm_rd_address,
  output logic        avm_rd_read,
  input  logic        avm_rd_waitrequest,
  input  logic [31:0] avm_rd_readdata,
  input  logic        avm_rd_readdatavalid,
  output logic [31:0] avm_wr_address,
  output logic        avm_wr_write,
  output logic [31:0] avm_wr_writedata,
  input  logic        avm_wr_waitrequest,
  output logic [31:0] dp_in_data,
  output logic        dp_in_valid,
  input  logic        dp_in_ready,
  input  logic [31:0] dp_out_data,
  input  logic        dp_out_valid,
  output logic        dp_out_ready
);

  localparam logic [15:0] LAST_CNT = 16'(FRAME_WORDS);
  localparam logic [31:0] STEP     = 32'(ADDR_STEP);

  typedef enum logic [1:0] {IDLE, RUN, DONE} top_state_t;
  typedef enum logic [1:0] {R_REQ, R_WAIT, R_PUSH, R_END} rd_state_t;
  typedef enum logic {W_ACC, W_WR} wr_state_t;

  top_state_t  top_state_reg, top_state_next;
  rd_state_t   rd_state_reg, rd_state_next;
  wr_state_t   wr_state_reg, wr_state_next;

  logic [15:0] rd_cnt_reg, rd_cnt_next;
  logic [15:0] wr_cnt_reg, wr_cnt_next;
  logic [31:0] rd_addr_reg, rd_addr_next;
  logic [31:0] wr_addr_reg, wr_addr_next;
  logic [31:0] rd_data_reg, rd_data_next;
  logic [31:0] wr_data_reg, wr_data_next;

  logic        rd_read_reg, rd_read_next;
  logic        dp_in_valid_reg, dp_in_valid_next;
  logic        wr_write_reg, wr_write_next;
  logic        dp_out_ready_reg, dp_out_ready_next;
  logic        busy_reg, busy_next;
  logic        irq_reg, irq_next;

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      top_state_reg    <= IDLE;
      rd_state_reg     <= R_END;
      wr_state_reg     <= W_ACC;
      rd_cnt_reg       <= '0;
      wr_cnt_reg       <= '0;
      rd_addr_reg      <= '0;
      wr_addr_reg      <= '0;
      rd_data_reg      <= '0;
      wr_data_reg      <= '0;
      rd_read_reg      <= 1'b0;
      dp_in_valid_reg  <= 1'b0;
      wr_write_reg     <= 1'b0;
      dp_out_ready_reg <= 1'b0;
      busy_reg         <= 1'b0;
      irq_reg          <= 1'b0;
    end else begin
      top_state_reg    <= top_state_next;
      rd_state_reg     <= rd_state_next;
      wr_state_reg     <= wr_state_next;
      rd_cnt_reg       <= rd_cnt_next;
      wr_cnt_reg       <= wr_cnt_next;
      rd_addr_reg      <= rd_addr_next;
      wr_addr_reg      <= wr_addr_next;
      rd_data_reg      <= rd_data_next;
      wr_data_reg      <= wr_data_next;
      rd_read_reg      <= rd_read_next;
      dp_in_valid_reg  <= dp_in_valid_next;
      wr_write_reg     <= wr_write_next;
      dp_out_ready_reg <= dp_out_ready_next;
      busy_reg         <= busy_next;
      irq_reg          <= irq_next;
    end
  end

  // Next-state and output decode
  always_comb begin
    top_state_next = top_state_reg;
    rd_state_next  = rd_state_reg;
    wr_state_next  = wr_state_reg;
    rd_cnt_next    = rd_cnt_reg;
    wr_cnt_next    = wr_cnt_reg;
    rd_addr_next   = rd_addr_reg;
    wr_addr_next   = wr_addr_reg;
    rd_data_next   = rd_data_reg;
    wr_data_next   = wr_data_reg;

    case (top_state_reg)
      IDLE: begin
        if (start) begin
          top_state_next = RUN;
          rd_state_next  = R_REQ;
          wr_state_next  = W_ACC;
          rd_cnt_next    = '0;
          wr_cnt_next    = '0;
          rd_addr_next   = start_addr_read;
          wr_addr_next   = start_addr_write;
        end
      end

      RUN: begin
        // Read side: request, wait for data, hand the word to the datapath
        case (rd_state_reg)
          R_REQ: begin
            if (!avm_rd_waitrequest) begin
              rd_state_next = R_WAIT;
            end
          end
          R_WAIT: begin
            if (avm_rd_readdatavalid) begin
              rd_data_next  = avm_rd_readdata;
              rd_state_next = R_PUSH;
            end
          end
          R_PUSH: begin
            if (dp_in_ready) begin
              rd_cnt_next   = rd_cnt_reg + 16'd1;
              rd_addr_next  = rd_addr_reg + STEP;
              rd_state_next = (rd_cnt_next == LAST_CNT) ? R_END : R_REQ;
            end
          end
          default: ;
        endcase

        // Write side: take one result, write it, repeat
        case (wr_state_reg)
          W_ACC: begin
            if (dp_out_valid && dp_out_ready_reg) begin
              wr_data_next  = dp_out_data;
              wr_state_next = W_WR;
            end
          end
          W_WR: begin
            if (!avm_wr_waitrequest) begin
              wr_cnt_next   = wr_cnt_reg + 16'd1;
              wr_addr_next  = wr_addr_reg + STEP;
              wr_state_next = W_ACC;
              // The frame ends on the edge that accepts the last write
              if (wr_cnt_next == LAST_CNT) begin
                top_state_next = DONE;
              end
            end
          end
          default: ;
        endcase
      end

      DONE: top_state_next = IDLE;

      default: top_state_next = IDLE;
    endcase

    // Outside RUN both sub-FSMs are parked so nothing is requested
    if (top_state_next != RUN) begin
      rd_state_next = R_END;
      wr_state_next = W_ACC;
    end

    rd_read_next      = (top_state_next == RUN) && (rd_state_next == R_REQ);
    dp_in_valid_next  = (top_state_next == RUN) && (rd_state_next == R_PUSH);
    wr_write_next     = (top_state_next == RUN) && (wr_state_next == W_WR);
    dp_out_ready_next = (top_state_next == RUN) && (wr_state_next == W_ACC) &&
                        (wr_cnt_next < LAST_CNT);
    busy_next         = (top_state_next != IDLE);
    irq_next          = (top_state_next == DONE);
  end

  assign irq              = irq_reg;
  assign busy             = busy_reg;
  assign avm_rd_address   = rd_addr_reg;
  assign avm_rd_read      = rd_read_reg;
  assign avm_wr_address   = wr_addr_reg;
  assign avm_wr_write     = wr_write_reg;
  assign avm_wr_writedata = wr_data_reg;
  assign dp_in_data       = rd_data_reg;
  assign dp_in_valid      = dp_in_valid_reg;
  assign dp_out_ready     = dp_out_ready_reg;

endmodule

// File: tb/tb_sig_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sig_frame_sequencer
//
// Bench for sig_frame_sequencer. There are two instances: dut_a with
// FRAME_WORDS=4 and dut_b with FRAME_WORDS=16. They share the memory and
// datapath models. `sel` picks which instance the models see. Expected writes
// are queued when a frame is started and are compared as the write master
// completes each write.
// -----------------------------------------------------------------------------
module tb_sig_frame_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] start_rd;
  logic [31:0] start_wr;
  logic        sel;

  // Model-driven DUT inputs
  logic        rd_wait, rd_vld;
  logic [31:0] rd_data;
  logic        wr_wait;
  logic        dp_in_ready;
  logic [31:0] dp_out_data;
  logic        dp_out_valid;

  // Per-instance outputs
  logic        a_irq, a_busy, a_rd_read, a_wr_write, a_dp_in_valid, a_dp_out_ready;
  logic [31:0] a_rd_addr, a_wr_addr, a_wr_data, a_dp_in_data;
  logic        b_irq, b_busy, b_rd_read, b_wr_write, b_dp_in_valid, b_dp_out_ready;
  logic [31:0] b_rd_addr, b_wr_addr, b_wr_data, b_dp_in_data;

  logic        start_a, start_b;
  assign start_a = start & ~sel;
  assign start_b = start & sel;

  // Outputs of the selected instance
  logic        m_irq, m_busy, m_rd_read, m_wr_write, m_dp_in_valid, m_dp_out_ready;
  logic [31:0] m_rd_addr, m_wr_addr, m_wr_data, m_dp_in_data;
  assign m_irq          = sel ? b_irq          : a_irq;
  assign m_busy         = sel ? b_busy         : a_busy;
  assign m_rd_read      = sel ? b_rd_read      : a_rd_read;
  assign m_rd_addr      = sel ? b_rd_addr      : a_rd_addr;
  assign m_wr_write     = sel ? b_wr_write     : a_wr_write;
  assign m_wr_addr      = sel ? b_wr_addr      : a_wr_addr;
  assign m_wr_data      = sel ? b_wr_data      : a_wr_data;
  assign m_dp_in_valid  = sel ? b_dp_in_valid  : a_dp_in_valid;
  assign m_dp_in_data   = sel ? b_dp_in_data   : a_dp_in_data;
  assign m_dp_out_ready = sel ? b_dp_out_ready : a_dp_out_ready;

  sig_frame_sequencer #(.FRAME_WORDS(4), .ADDR_STEP(4)) dut_a (
    .clk(clk), .rst(rst), .start(start_a),
    .start_addr_read(start_rd), .start_addr_write(start_wr),
    .irq(a_irq), .busy(a_busy),
    .avm_rd_address(a_rd_addr), .avm_rd_read(a_rd_read),
    .avm_rd_waitrequest(rd_wait), .avm_rd_readdata(rd_data),
    .avm_rd_readdatavalid(rd_vld),
    .avm_wr_address(a_wr_addr), .avm_wr_write(a_wr_write),
    .avm_wr_writedata(a_wr_data), .avm_wr_waitrequest(wr_wait),
    .dp_in_data(a_dp_in_data), .dp_in_valid(a_dp_in_valid), .dp_in_ready(dp_in_ready),
    .dp_out_data(dp_out_data), .dp_out_valid(dp_out_valid), .dp_out_ready(a_dp_out_ready)
  );

  sig_frame_sequencer #(.FRAME_WORDS(16), .ADDR_STEP(4)) dut_b (
    .clk(clk), .rst(rst), .start(start_b),
    .start_addr_read(start_rd), .start_addr_write(start_wr),
    .irq(b_irq), .busy(b_busy),
    .avm_rd_address(b_rd_addr), .avm_rd_read(b_rd_read),
    .avm_rd_waitrequest(rd_wait), .avm_rd_readdata(rd_data),
    .avm_rd_readdatavalid(rd_vld),
    .avm_wr_address(b_wr_addr), .avm_wr_write(b_wr_write),
    .avm_wr_writedata(b_wr_data), .avm_wr_waitrequest(wr_wait),
    .dp_in_data(b_dp_in_data), .dp_in_valid(b_dp_in_valid), .dp_in_ready(dp_in_ready),
    .dp_out_data(dp_out_data), .dp_out_valid(dp_out_valid), .dp_out_ready(b_dp_out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counters and model knobs
  int vec_cnt = 0;
  int mis_cnt = 0;
  int irq_cnt = 0;
  int wr_in_frame = 0;
  int extra_seen = 0;
  int sent_cnt = 0;
  int cyc = 0;
  bit stress = 0;
  bit bp = 0;
  bit extra_en = 0;
  int lat = 1;

  logic [31:0] rom [logic [31:0]];
  logic [31:0] mem_wr [logic [31:0]];

  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_exp_t;
  wr_exp_t exp_q[$];

  typedef struct { logic [31:0] data; int t; } pipe_t;
  pipe_t pipe_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      mis_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return rom.exists(a) ? rom[a] : (a ^ 32'h5A5A_A5A5);
  endfunction

  function automatic logic [31:0] wr_at(input logic [31:0] a);
    return mem_wr.exists(a) ? mem_wr[a] : 32'hxxxx_xxxx;
  endfunction

  // ---------------- read slave ----------------
  bit          rd_armed = 0, rd_pend = 0, rd_in_req = 0;
  int          rd_stall = 0, rd_pend_dly = 0;
  logic [31:0] rd_req_addr = 0, rd_acc_addr = 0, rd_pend_addr = 0;

  always @(negedge clk) begin
    if (!rst) begin
      rd_wait = 0; rd_vld = 0; rd_data = 0;
      rd_armed = 0; rd_pend = 0; rd_in_req = 0; rd_stall = 0;
    end else begin
      rd_vld = 0; rd_data = 0;
      if (rd_armed) begin
        rd_armed = 0; rd_in_req = 0;
        rd_pend = 1; rd_pend_addr = rd_acc_addr;
        rd_pend_dly = stress ? int'($urandom_range(3, 0)) : 0;
      end
      if (rd_pend) begin
        if (rd_pend_dly == 0) begin
          rd_vld = 1; rd_data = mem_val(rd_pend_addr); rd_pend = 0;
        end else begin
          rd_pend_dly--;
        end
      end else if (stress && $urandom_range(3, 0) == 0) begin
        // stray valid while no read is outstanding; must be ignored
        rd_vld = 1; rd_data = 32'hBADB_AD00;
      end
      if (rd_in_req) begin
        check("rd_read_hold", {31'd0, m_rd_read}, 32'd1);
        check("rd_addr_hold", m_rd_addr, rd_req_addr);
      end else if (m_rd_read) begin
        rd_in_req = 1; rd_req_addr = m_rd_addr;
        rd_stall = stress ? int'($urandom_range(5, 0)) : 0;
      end
      if (rd_in_req) begin
        if (rd_stall > 0) begin
          rd_wait = 1; rd_stall--;
        end else begin
          rd_wait = 0; rd_armed = 1; rd_acc_addr = rd_req_addr;
        end
      end else begin
        rd_wait = stress ? 1'($urandom_range(1, 0)) : 1'b0;
      end
    end
  end

  // ---------------- write slave + scoreboard ----------------
  bit          wr_armed = 0, wr_in_req = 0;
  int          wr_stall = 0;
  logic [31:0] wr_req_addr = 0, wr_req_data = 0;

  always @(negedge clk) begin
    if (!rst) begin
      wr_wait = 0; wr_armed = 0; wr_in_req = 0; wr_stall = 0; wr_in_frame = 0;
    end else begin
      if (wr_armed) begin
        wr_exp_t e;
        wr_armed = 0; wr_in_req = 0;
        check("wr_expected", {31'd0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("wr_addr", wr_req_addr, e.addr);
          check("wr_data", wr_req_data, e.data);
        end
        mem_wr[wr_req_addr] = wr_req_data;
        wr_in_frame++;
        $display("write %0d: addr %h data %h", wr_in_frame, wr_req_addr, wr_req_data);
      end else if (!m_busy) begin
        wr_in_frame = 0;
      end
      if (wr_in_req) begin
        check("wr_write_hold", {31'd0, m_wr_write}, 32'd1);
        check("wr_addr_hold", m_wr_addr, wr_req_addr);
        check("wr_data_hold", m_wr_data, wr_req_data);
      end else if (m_wr_write) begin
        wr_in_req = 1; wr_req_addr = m_wr_addr; wr_req_data = m_wr_data;
        wr_stall = stress ? int'($urandom_range(5, 0)) : 0;
      end
      if (wr_in_req) begin
        if (wr_stall > 0) begin
          wr_wait = 1; wr_stall--;
        end else begin
          wr_wait = 0; wr_armed = 1;
        end
      end else begin
        wr_wait = stress ? 1'($urandom_range(1, 0)) : 1'b0;
      end
    end
  end

  // ---------------- identity datapath with latency ----------------
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      pipe_q.delete();
      dp_in_ready = 0; dp_out_valid = 0; dp_out_data = 0; sent_cnt = 0;
    end else begin
      if (!m_busy) sent_cnt = 0;
      dp_in_ready = bp ? 1'($urandom_range(1, 0)) : 1'b1;
      if (m_dp_in_valid && dp_in_ready) pipe_q.push_back('{m_dp_in_data, cyc + lat});
      dp_out_valid = 0; dp_out_data = 0;
      if (pipe_q.size() > 0 && pipe_q[0].t <= cyc) begin
        dp_out_valid = 1; dp_out_data = pipe_q[0].data;
        if (m_dp_out_ready) begin
          void'(pipe_q.pop_front());
          sent_cnt++;
        end
      end else if (extra_en && m_busy && sent_cnt >= (sel ? 16 : 4)) begin
        // one result more than the frame holds; must not be taken
        dp_out_valid = 1; dp_out_data = 32'hDEAD_0017;
        check("dp_out_ready_extra", {31'd0, m_dp_out_ready}, 32'd0);
        extra_seen++;
      end
    end
  end

  // irq pulse counter
  always @(negedge clk) begin
    if (rst && m_irq) irq_cnt++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_expect(input logic [31:0] ra, input logic [31:0] wa, input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] off;
      off = 32'(i) * 32'd4;
      exp_q.push_back('{wa + off, mem_val(ra + off)});
    end
  endtask

  task automatic pulse_start(input logic [31:0] ra, input logic [31:0] wa, input bit chk);
    @(negedge clk);
    start = 1; start_rd = ra; start_wr = wa;
    @(negedge clk);
    start = 0;
    if (chk) begin
      check("busy_k1", {31'd0, m_busy}, 32'd1);
      check("rd_read_k1", {31'd0, m_rd_read}, 32'd1);
      check("dp_out_ready_k1", {31'd0, m_dp_out_ready}, 32'd1);
    end
  endtask

  task automatic wait_irq(input string tag);
    bit seen;
    seen = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (m_irq) begin
        seen = 1;
        break;
      end
    end
    check({tag, "_irq_seen"}, {31'd0, seen}, 32'd1);
    if (seen) begin
      check({tag, "_busy_at_irq"}, {31'd0, m_busy}, 32'd1);
      @(negedge clk);
      check({tag, "_busy_after_irq"}, {31'd0, m_busy}, 32'd0);
      check({tag, "_irq_one_cycle"}, {31'd0, m_irq}, 32'd0);
      check({tag, "_all_written"}, exp_q.size(), 32'd0);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_irq"}, {31'd0, m_irq}, 32'd0);
    check({tag, "_busy"}, {31'd0, m_busy}, 32'd0);
    check({tag, "_rd_read"}, {31'd0, m_rd_read}, 32'd0);
    check({tag, "_wr_write"}, {31'd0, m_wr_write}, 32'd0);
    check({tag, "_dp_in_valid"}, {31'd0, m_dp_in_valid}, 32'd0);
    check({tag, "_dp_out_ready"}, {31'd0, m_dp_out_ready}, 32'd0);
    check({tag, "_rd_addr"}, m_rd_addr, 32'd0);
    check({tag, "_wr_addr"}, m_wr_addr, 32'd0);
    check({tag, "_wr_data"}, m_wr_data, 32'd0);
    check({tag, "_dp_in_data"}, m_dp_in_data, 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit found;
    int irq_before;
    rst = 0; start = 0; start_rd = 0; start_wr = 0; sel = 0;
    rom[32'h1000] = 32'h11; rom[32'h1004] = 32'h22;
    rom[32'h1008] = 32'h33; rom[32'h100C] = 32'h44;

    // Reset state of both instances
    repeat (3) @(negedge clk);
    check_outputs_zero("reset_a");
    sel = 1;
    #1 check_outputs_zero("reset_b");
    sel = 0;
    @(negedge clk);
    rst = 1;
    repeat (2) @(negedge clk);

    // Identity frame
    push_expect(32'h1000, 32'h2000, 4);
    pulse_start(32'h1000, 32'h2000, 1);
    wait_irq("identity");
    check("identity_w0", wr_at(32'h2000), 32'h11);
    check("identity_w1", wr_at(32'h2004), 32'h22);
    check("identity_w2", wr_at(32'h2008), 32'h33);
    check("identity_w3", wr_at(32'h200C), 32'h44);
    check("identity_irq_count", irq_cnt, 32'd1);
    $display("frame identity done, irq_cnt %0d", irq_cnt);

    // Same frame under random wait states
    mem_wr.delete();
    stress = 1;
    push_expect(32'h1000, 32'h2000, 4);
    pulse_start(32'h1000, 32'h2000, 1);
    wait_irq("waitstates");
    check("waitstates_w0", wr_at(32'h2000), 32'h11);
    check("waitstates_w1", wr_at(32'h2004), 32'h22);
    check("waitstates_w2", wr_at(32'h2008), 32'h33);
    check("waitstates_w3", wr_at(32'h200C), 32'h44);
    check("waitstates_irq_count", irq_cnt, 32'd2);
    $display("frame waitstates done, irq_cnt %0d", irq_cnt);

    // 16-word frame with input backpressure and a 7-cycle datapath
    stress = 0; bp = 1; lat = 7; extra_en = 1; sel = 1;
    repeat (2) @(negedge clk);
    push_expect(32'h4000, 32'h8000, 16);
    pulse_start(32'h4000, 32'h8000, 1);
    wait_irq("backpressure");
    check("backpressure_extra_driven", {31'd0, extra_seen > 0}, 32'd1);
    check("backpressure_irq_count", irq_cnt, 32'd3);
    $display("frame backpressure done, irq_cnt %0d", irq_cnt);

    // Start while busy is ignored
    bp = 0; lat = 1; extra_en = 0; stress = 1; sel = 0;
    repeat (2) @(negedge clk);
    push_expect(32'h1000, 32'h5000, 4);
    pulse_start(32'h1000, 32'h5000, 1);
    found = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (wr_in_frame >= 1) begin
        found = 1;
        break;
      end
    end
    check("busy_start_midframe_reached", {31'd0, found}, 32'd1);
    pulse_start(32'h7000, 32'h9000, 0);
    wait_irq("busy_start");
    check("busy_start_irq_count", irq_cnt, 32'd4);
    check("busy_start_no_dest2", {31'd0, mem_wr.exists(32'h9000)}, 32'd0);
    push_expect(32'h7000, 32'h9000, 4);
    pulse_start(32'h7000, 32'h9000, 1);
    wait_irq("fresh_start");
    check("fresh_start_irq_count", irq_cnt, 32'd5);
    $display("frame start-while-busy done, irq_cnt %0d", irq_cnt);

    // Reset during the write of word 2
    push_expect(32'h1000, 32'h6000, 4);
    pulse_start(32'h1000, 32'h6000, 1);
    found = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (wr_in_frame == 2 && m_wr_write) begin
        found = 1;
        break;
      end
    end
    check("reset_midframe_reached", {31'd0, found}, 32'd1);
    irq_before = irq_cnt;
    #2 rst = 0;
    #1 check_outputs_zero("async_reset");
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1;
    repeat (6) @(negedge clk);
    check("reset_no_irq", irq_cnt, irq_before);
    push_expect(32'h1000, 32'hA000, 4);
    pulse_start(32'h1000, 32'hA000, 1);
    wait_irq("after_reset");
    check("after_reset_irq_count", irq_cnt, irq_before + 1);
    $display("frame reset-midframe done, irq_cnt %0d", irq_cnt);

    // Destination address wraps through zero
    stress = 0;
    push_expect(32'h3000, 32'hFFFF_FFF8, 4);
    pulse_start(32'h3000, 32'hFFFF_FFF8, 1);
    wait_irq("wrap");
    check("wrap_w0", wr_at(32'hFFFF_FFF8), mem_val(32'h3000));
    check("wrap_w1", wr_at(32'hFFFF_FFFC), mem_val(32'h3004));
    check("wrap_w2", wr_at(32'h0000_0000), mem_val(32'h3008));
    check("wrap_w3", wr_at(32'h0000_0004), mem_val(32'h300C));
    $display("frame wrap done, irq_cnt %0d", irq_cnt);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
    $finish;
  end

endmodule
